fifo_top: RTL and testbench



---
 rtl/fifo_top.sv | 61 ++++++
 tb/tb_fifo_top.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_top.sv
// Synchronous show-ahead FIFO, depth 2**ASIZE, width DSIZE.
// Define FIFO_LEVEL_EN to add the occupancy output port 'level'.
module fifo_top #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             w_valid,
  output logic             wfull,
  output logic [DSIZE-1:0] rdata,
  input  logic             r_valid,
  output logic             rempty
`ifdef FIFO_LEVEL_EN
  ,
  output logic [ASIZE:0]   level
`endif
);

  localparam int DEPTH = 2 ** ASIZE;
  localparam logic [ASIZE:0] ONE = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             push;
  logic             pop;

  assign push = w_valid && !wfull;
  assign pop  = r_valid && !rempty;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
    end
  end

  // Array is cleared on reset so rdata reads 0 until the first write.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  assign rdata  = mem[rptr[ASIZE-1:0]];
  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                  (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);

`ifdef FIFO_LEVEL_EN
  assign level = wptr - rptr;
`endif

endmodule

// File: tb/tb_fifo_top.sv
// Directed self-checking bench for fifo_top.
// Covers reset, fill/drain, show-ahead, wrap, simultaneous r/w, async reset.
module tb_fifo_top;

  logic       wclk;
  logic       wrst_n;
  logic [7:0] wdata;
  logic       w_valid;
  logic       wfull;
  logic [7:0] rdata;
  logic       r_valid;
  logic       rempty;
`ifdef FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];

  fifo_top #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .wdata   (wdata),
    .w_valid (w_valid),
    .wfull   (wfull),
    .rdata   (rdata),
    .r_valid (r_valid),
    .rempty  (rempty)
`ifdef FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef FIFO_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`endif
  endtask

  initial begin
    wrst_n  = 1'b0;
    wdata   = 8'hFF;
    w_valid = 1'b1;
    r_valid = 1'b1;

    // Reset held 10 cycles with requests toggling
    for (int i = 0; i < 10; i++) begin
      w_valid = i[0];
      r_valid = !i[0];
      step();
    end
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h00);
    check_level("rst_level", 0);

    w_valid = 1'b0;
    r_valid = 1'b0;
    wrst_n  = 1'b1;
    step();
    check("post_rst_rempty", 32'(rempty), 32'd1);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wdata   = 8'(i);
      w_valid = 1'b1;
      step();
      if (i == 1) check("fill_first_rdata", 32'(rdata), 32'h01);
      if (i == 15) check("fill15_wfull", 32'(wfull), 32'd0);
      check_level("fill_level", i);
    end
    check("fill16_wfull", 32'(wfull), 32'd1);
    check("fill16_rempty", 32'(rempty), 32'd0);

    wdata = 8'hAA;
    step();
    w_valid = 1'b0;
    check("drop_wfull", 32'(wfull), 32'd1);
    check("drop_rdata", 32'(rdata), 32'h01);
    check_level("drop_level", 16);

    // Drain 16
    for (int i = 1; i <= 16; i++) begin
      r_valid = 1'b1;
      check("drain_rdata", 32'(rdata), 32'(i));
      step();
      check_level("drain_level", 16 - i);
    end
    r_valid = 1'b0;
    check("drain_rempty", 32'(rempty), 32'd1);
    check("drain_wfull", 32'(wfull), 32'd0);
    check("stale_rdata", 32'(rdata), 32'h01);

    // Extra pop on empty must be ignored
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    check("empty_pop_rempty", 32'(rempty), 32'd1);
    check_level("empty_pop_level", 0);

    // Show-ahead
    wdata   = 8'h5C;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    check("sa_rempty", 32'(rempty), 32'd0);
    check("sa_rdata", 32'(rdata), 32'h5C);
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    check("sa_pop_rempty", 32'(rempty), 32'd1);

    // Alternating, two rounds of 30 cycles
    for (int c = 0; c < 60; c++) begin
      w_valid = (c % 2 == 0);
      wdata   = 8'($urandom);
      r_valid = (c % 2 == 1) && !rempty;
      check("alt_rempty", 32'(rempty), 32'(q.size() == 0));
      if (r_valid) check("alt_rdata", 32'(rdata), 32'(q[0]));
      step();
      if (w_valid) q.push_back(wdata);
      if (r_valid) void'(q.pop_front());
    end
    w_valid = 1'b0;
    r_valid = 1'b0;
    check("alt_end_rempty", 32'(rempty), 32'd1);

    // Simultaneous with 8 stored
    for (int i = 0; i < 8; i++) begin
      wdata   = 8'($urandom);
      w_valid = 1'b1;
      step();
      q.push_back(wdata);
    end
    for (int c = 0; c < 20; c++) begin
      wdata   = 8'($urandom);
      w_valid = 1'b1;
      r_valid = 1'b1;
      check("sim_rdata", 32'(rdata), 32'(q[0]));
      step();
      void'(q.pop_front());
      q.push_back(wdata);
      check("sim_rempty", 32'(rempty), 32'd0);
      check("sim_wfull", 32'(wfull), 32'd0);
      check_level("sim_level", 8);
    end
    w_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r_valid = 1'b1;
      check("sim_drain", 32'(rdata), 32'(q[0]));
      step();
      void'(q.pop_front());
    end
    r_valid = 1'b0;
    check("sim_drain_rempty", 32'(rempty), 32'd1);

    // Full plus simultaneous read/write: pop one, drop write
    for (int i = 0; i < 16; i++) begin
      wdata   = 8'(8'h20 + i);
      w_valid = 1'b1;
      step();
    end
    check("full2_wfull", 32'(wfull), 32'd1);
    wdata   = 8'hEE;
    r_valid = 1'b1;
    check("full_rw_rdata", 32'(rdata), 32'h20);
    step();
    w_valid = 1'b0;
    r_valid = 1'b0;
    check("full_rw_wfull", 32'(wfull), 32'd0);
    check_level("full_rw_level", 15);
    for (int i = 1; i < 16; i++) begin
      r_valid = 1'b1;
      check("full_rw_drain", 32'(rdata), 32'(8'h20 + i));
      step();
    end
    r_valid = 1'b0;
    check("full_rw_rempty", 32'(rempty), 32'd1);

    // Mid-run asynchronous reset with 5 stored
    for (int i = 0; i < 5; i++) begin
      wdata   = 8'(8'h40 + i);
      w_valid = 1'b1;
      step();
    end
    w_valid = 1'b0;
    check("pre_rst_rempty", 32'(rempty), 32'd0);
    #2 wrst_n = 1'b0;
    #1;
    check("arst_rempty", 32'(rempty), 32'd1);
    check("arst_wfull", 32'(wfull), 32'd0);
    check("arst_rdata", 32'(rdata), 32'h00);
    check_level("arst_level", 0);
    #1 wrst_n = 1'b1;
    step();
    check("post_arst_rempty", 32'(rempty), 32'd1);
    wdata   = 8'h33;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    check("arst_w_rempty", 32'(rempty), 32'd0);
    check("arst_w_rdata", 32'(rdata), 32'h33);
    r_valid = 1'b1;
    step();
    r_valid = 1'b0;
    check("arst_final_rempty", 32'(rempty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
